// File: rtl/aes_pkg.sv
// Shared AES constants, key-size encodings and the round-key sequencer FSM state type.
// Used by round_key_sequencer and round_key_mux.
package aes_pkg;

    localparam int KEY_W = 128;
    localparam int EXP_W = 1920;

    localparam logic [2:0] KEYSIZE_128 = 3'b000;
    localparam logic [2:0] KEYSIZE_192 = 3'b010;
    localparam logic [2:0] KEYSIZE_256 = 3'b100;

    localparam logic [3:0] NKEYS_128 = 4'd11;
    localparam logic [3:0] NKEYS_192 = 4'd13;
    localparam logic [3:0] NKEYS_256 = 4'd15;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    // Unrecognised key-size codes fall back to AES-128.
    function automatic logic [3:0] key_count(input logic [2:0] key_size);
        case (key_size)
            KEYSIZE_192: return NKEYS_192;
            KEYSIZE_256: return NKEYS_256;
            default:     return NKEYS_128;
        endcase
    endfunction

endpackage

// File: rtl/round_key_mux.sv
// Combinational slice select: returns round key `slot` from a big-endian expanded-key buffer.
// Slots past the last round key read as zero.
module round_key_mux
    import aes_pkg::*;
#(
    parameter int KEY_W = aes_pkg::KEY_W,
    parameter int EXP_W = aes_pkg::EXP_W
) (
    input  logic [0:EXP_W-1] buf_in,
    input  logic [3:0]       slot,
    output logic [0:KEY_W-1] key
);

    always_comb begin
        key = '0;
        for (int i = 0; i < EXP_W / KEY_W; i++) begin
            if (slot == i[3:0]) begin
                key = buf_in[i*KEY_W +: KEY_W];
            end
        end
    end

endmodule

// File: rtl/round_key_sequencer.sv
// Captures an expanded AES key and streams its round keys (forward or reverse) over valid/ready.
// Optional build macro ROUND_KEY_ZEROIZE_EN wipes the key buffer and rkData at the end of a stream.
module round_key_sequencer
    import aes_pkg::*;
#(
    parameter int KEY_W = aes_pkg::KEY_W,
    parameter int EXP_W = aes_pkg::EXP_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       keySize,
    input  logic             decrypt,
    input  logic [0:EXP_W-1] keyExp,
    output logic             busy,
    output logic             rkValid,
    input  logic             rkReady,
    output logic [0:KEY_W-1] rkData,
    output logic [3:0]       rkIndex,
    output logic             rkLast,
    output logic             done,
    output state_t           dbg_state
);

`ifdef ROUND_KEY_ZEROIZE_EN
    localparam bit ZEROIZE = 1'b1;
`else
    localparam bit ZEROIZE = 1'b0;
`endif

    state_t           state;
    logic [0:EXP_W-1] key_buf;
    logic [3:0]       key_cnt;
    logic [3:0]       ptr;
    logic             dec_q;

    logic             accept;
    logic             xfer;
    logic [3:0]       cnt_new;
    logic [0:EXP_W-1] mux_src;
    logic [3:0]       mux_slot;
    logic [0:KEY_W-1] mux_key;

    // Handshake: a key moves when rkValid && rkReady at a rising edge; while rkValid is
    // high and rkReady low, rkData/rkIndex/rkLast hold. rkValid never depends on rkReady
    // combinationally, and once raised drops only after the final transfer (or reset).
    always_comb begin
        accept  = (state == ST_IDLE) && start;
        xfer    = rkValid && rkReady;
        cnt_new = key_count(keySize);
        if (accept) begin
            mux_src  = keyExp;
            mux_slot = decrypt ? (cnt_new - 4'd1) : 4'd0;
        end else begin
            mux_src  = key_buf;
            mux_slot = dec_q ? (ptr - 4'd1) : (ptr + 4'd1);
        end
    end

    round_key_mux #(.KEY_W(KEY_W), .EXP_W(EXP_W)) u_mux (
        .buf_in (mux_src),
        .slot   (mux_slot),
        .key    (mux_key)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            key_buf <= '0;
            key_cnt <= NKEYS_128;
            ptr     <= 4'd0;
            dec_q   <= 1'b0;
            busy    <= 1'b0;
            rkValid <= 1'b0;
            rkData  <= '0;
            rkIndex <= 4'd0;
            rkLast  <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state   <= ST_STREAM;
                        key_buf <= keyExp;
                        key_cnt <= cnt_new;
                        dec_q   <= decrypt;
                        ptr     <= mux_slot;
                        rkData  <= mux_key;
                        rkIndex <= 4'd0;
                        rkLast  <= 1'b0;
                        rkValid <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                ST_STREAM: begin
                    if (xfer) begin
                        rkIndex <= rkIndex + 4'd1;
                        ptr     <= mux_slot;
                        if (rkLast) begin
                            state   <= ST_IDLE;
                            rkValid <= 1'b0;
                            busy    <= 1'b0;
                            rkLast  <= 1'b0;
                            done    <= 1'b1;
                            if (ZEROIZE) begin
                                key_buf <= '0;
                                rkData  <= '0;
                            end
                        end else begin
                            rkData <= mux_key;
                            rkLast <= ((rkIndex + 4'd1) == (key_cnt - 4'd1));
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign dbg_state = state;

endmodule
